// File: rtl/segment_sequencer.sv
// segment_sequencer
// Walks a captured 128-bit msg/key pair through a 16-bit segment engine,
// one segment at a time (segment 0 = LSB slice), and reassembles the engine
// results into a 128-bit output word.
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   in_valid/in_ready, msg/key - input pair handshake (accepted in IDLE)
//   seg_valid/seg_ready        - segment issue handshake to the engine
//   msg_p/key_p/seg_idx        - current segment slices and index
//   res_valid/res_data         - engine result (sampled only in WAIT)
//   out_valid/out_ready        - reassembled word handshake
//   out_data                   - reassembled result word
//   busy                       - high whenever not in IDLE
module segment_sequencer #(
  parameter int unsigned SEG_W = 16,
  parameter int unsigned NSEG  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEG_W*NSEG-1:0]    msg,
  input  logic [SEG_W*NSEG-1:0]    key,
  output logic                     seg_valid,
  input  logic                     seg_ready,
  output logic [SEG_W-1:0]         msg_p,
  output logic [SEG_W-1:0]         key_p,
  output logic [$clog2(NSEG)-1:0]  seg_idx,
  input  logic                     res_valid,
  input  logic [SEG_W-1:0]         res_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEG_W*NSEG-1:0]    out_data,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(NSEG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [SEG_W*NSEG-1:0]   msg_r;
  logic [SEG_W*NSEG-1:0]   key_r;

  // Handshake flags are registered alongside the state so each one is a
  // flop output that always equals its decode of the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      seg_idx   <= '0;
      msg_r     <= '0;
      key_r     <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      seg_valid <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            msg_r     <= msg;
            key_r     <= key;
            out_data  <= '0;
            seg_idx   <= '0;
            state     <= ISSUE;
            in_ready  <= 1'b0;
            seg_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (seg_ready) begin
            state     <= WAIT;
            seg_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (res_valid) begin
            out_data[seg_idx*SEG_W +: SEG_W] <= res_data;
            if (seg_idx == LAST_IDX) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              seg_idx   <= seg_idx + 1'b1;
              state     <= ISSUE;
              seg_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          seg_valid <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    msg_p = msg_r[seg_idx*SEG_W +: SEG_W];
    key_p = key_r[seg_idx*SEG_W +: SEG_W];
  end

endmodule

// File: tb/tb_segment_sequencer.sv
// Self-checking bench for segment_sequencer: table of word-level vectors
// driven through an XOR engine model, plus a hand-written reset-abort case.
module tb_segment_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] msg;
  logic [127:0] key;
  logic         seg_valid;
  logic         seg_ready;
  logic [15:0]  msg_p;
  logic [15:0]  key_p;
  logic [2:0]   seg_idx;
  logic         res_valid;
  logic [15:0]  res_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  segment_sequencer #(.SEG_W(16), .NSEG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .msg(msg), .key(key),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .msg_p(msg_p), .key_p(key_p), .seg_idx(seg_idx),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  typedef struct {
    logic [127:0] msg;
    logic [127:0] key;
    logic [127:0] exp_out;
    int unsigned  stall_seg;
    int unsigned  stall_n;
    int unsigned  ostall;
    bit           spur;
    bit           hold;
    int unsigned  exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_word(input vec_t v, input logic [127:0] nmsg, input logic [127:0] nkey);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    int unsigned sleft = v.stall_n;
    int unsigned oleft = v.ostall;
    bit pend = 0;
    bit done = 0;
    bit first = 1;
    logic [15:0] exp_res = '0;

    if (v.spur) begin
      in_valid = 1'b0; res_valid = 1'b1; res_data = 16'hDEAD;
      step();
      res_valid = 1'b0;
    end
    msg = v.msg; key = v.key; in_valid = 1'b1;
    chk("idle_in_ready", {127'd0, in_ready}, 128'd1);
    chk("idle_busy", {127'd0, busy}, 128'd0);
    step();
    in_valid = v.hold;
    msg = ~v.msg; key = ~v.key;
    for (int c = 0; c < 200 && !done; c++) begin
      cyc++;
      seg_ready = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
      chk("busy", {127'd0, busy}, 128'd1);
      if (seg_valid) begin
        chk("issue_idx", {125'd0, seg_idx}, 128'(idx));
        chk("msg_p", {112'd0, msg_p}, {112'd0, v.msg[idx*16 +: 16]});
        chk("key_p", {112'd0, key_p}, {112'd0, v.key[idx*16 +: 16]});
        if (idx == v.stall_seg && sleft > 0) begin
          sleft--;
        end else begin
          seg_ready = 1'b1;
          pend = 1;
          exp_res = v.msg[idx*16 +: 16] ^ v.key[idx*16 +: 16];
          if (v.spur) begin
            res_valid = 1'b1; res_data = 16'hDEAD;
          end
        end
      end else if (pend) begin
        chk("wait_idx", {125'd0, seg_idx}, 128'(idx));
        chk("wait_out_valid", {127'd0, out_valid}, 128'd0);
        res_valid = 1'b1; res_data = exp_res;
        pend = 0;
        idx++;
      end else if (out_valid) begin
        if (first) begin
          chk("latency", 128'(cyc), 128'(v.exp_lat));
          first = 0;
        end
        chk("out_data", out_data, v.exp_out);
        chk("done_in_ready", {127'd0, in_ready}, 128'd0);
        if (v.spur) begin
          res_valid = 1'b1; res_data = 16'hDEAD;
        end
        if (oleft > 0) begin
          oleft--;
          msg = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else begin
          out_ready = 1'b1;
          done = 1;
          if (v.hold) begin
            in_valid = 1'b1; msg = nmsg; key = nkey;
          end
        end
      end else begin
        chk("unexpected_state", {127'd0, busy}, 128'd0);
        done = 1;
      end
      if (!done) step();
    end
    if (!done) chk("timeout", 128'd1, 128'd0);
    step();
    out_ready = 1'b0; res_valid = 1'b0; seg_ready = 1'b0;
    chk("post_out_valid", {127'd0, out_valid}, 128'd0);
    chk("post_in_ready", {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    vecs[0] = '{128'h0123456789ABCDEF_FEDCBA9876543210, {16{8'h0F}},
                128'h0E2C4A6886A4C2E0_F1D3B597795B3D1F, 0, 0, 0, 0, 0, 17};
    vecs[1] = '{128'h0123456789ABCDEF_FEDCBA9876543210, {16{8'h0F}},
                128'h0E2C4A6886A4C2E0_F1D3B597795B3D1F, 2, 3, 0, 0, 0, 20};
    vecs[2] = '{{32{4'h1}}, {32{4'h2}}, {32{4'h3}}, 0, 0, 0, 1, 0, 17};
    vecs[3] = '{{32{4'hA}}, {32{4'h5}}, {32{4'hF}}, 0, 0, 5, 0, 0, 17};
    vecs[4] = '{128'h0123456789ABCDEF_FEDCBA9876543210, {128{1'b1}},
                128'hFEDCBA9876543210_0123456789ABCDEF, 0, 0, 0, 0, 1, 17};
    vecs[5] = '{128'h0123456789ABCDEF_FEDCBA9876543210, {16{8'h0F}},
                128'h0E2C4A6886A4C2E0_F1D3B597795B3D1F, 0, 0, 0, 0, 0, 17};

    rst_n = 1'b0; in_valid = 1'b0; msg = '1; key = '1;
    seg_ready = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_seg_valid", {127'd0, seg_valid}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_seg_idx", {125'd0, seg_idx}, 128'd0);
    chk("rst_msg_p", {112'd0, msg_p}, 128'd0);
    chk("rst_key_p", {112'd0, key_p}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);

    for (int i = 0; i < 6; i++) begin
      if (i < 5) run_word(vecs[i], vecs[i+1].msg, vecs[i+1].key);
      else       run_word(vecs[i], '0, '0);
    end

    // Reset during segment 4 WAIT aborts the word.
    in_valid = 1'b1; msg = {32{4'h7}}; key = {32{4'h8}};
    step();
    in_valid = 1'b0;
    seg_ready = 1'b1; res_valid = 1'b1; res_data = 16'h1234;
    begin
      bit hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
        step();
        if (!seg_valid && busy && !out_valid && seg_idx == 3'd4) hit = 1;
      end
      chk("reach_seg4_wait", {127'd0, hit}, 128'd1);
    end
    rst_n = 1'b0; seg_ready = 1'b0; res_valid = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_out_data", out_data, 128'd0);
    chk("abort_seg_idx", {125'd0, seg_idx}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    run_word(vecs[0], '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
